cos_lut: RTL and testbench
==========================

Name: cos_lut

Overview:
- Synchronous cosine look-up table for the BPSK modem carrier path.
- Maps a phase index k in [0, N-1] to cos(2*pi*k/N) in 24-bit signed fixed point.
- Has READ_PORTS independent read ports sharing one table.
- Feeds the carrier mixer/NCO, which steps the phase index once per sample.

Parameters:
- READ_PORTS, 1, number of independent read ports (>=1).
- SAMPLES_PER_PERIOD, 64, carrier samples per period N; power of two, >=8 (codebase default from CARRIER_SAMPLES_PER_PERIOD).
- OUT_WIDTH, 24, output word width (codebase FIXDT_24_WIDTH).
- FRAC_BITS, 22, fractional bits of output; format is signed Q2.22, so 1.0 = 0x400000.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  unpacked array [READ_PORTS] of $clog2(SAMPLES_PER_PERIOD) bits  phase index per port.
- out  output  unpacked array [READ_PORTS] of OUT_WIDTH bits  signed cosine sample per port.

Behaviour:
- Table entry k = round_half_away(cos(2*pi*k/N) * 2^FRAC_BITS), two's complement, computed at elaboration.
- No runtime writes to the table.
- +1.0 = 0x400000 and -1.0 = 0xC00000 are exact; no saturation is needed.
- Output is registered with 1-cycle latency: in[p] sampled at edge t, out[p] valid after edge t and held until edge t+1.
- Ports are fully independent; identical addresses on several ports in the same cycle are legal and return identical data.
- Reset: while rst=1 at a rising edge, every out[p] <= 0. The first valid sample appears on the first edge with rst=0.
- Reset asserted mid-stream clears outputs on that edge; no other state exists.
- Index wrap: in is exactly log2(N) bits, so index N-1 followed by 0 wraps naturally; no out-of-range case exists.
- Symmetry guarantees:
  - out(k) == out(N-k) for k>0.
  - out(k+N/2) == -out(k) exactly, bit for bit.
- No handshake; every cycle is a read.

Optional Feature:
- Macro COS_LUT_QUARTER_WAVE_EN.
- Defined:
  - Store only N/4+1 entries (k = 0..N/4).
  - Fold the index: quadrant q = in[MSB:MSB-1]; mirror the offset for q=1 and q=3; negate for q=1 and q=2; index N/4 returns 0.
  - Fold and negate happen in the same single registered stage, so latency stays 1.
- Undefined: full N-entry table, direct index.
- Outputs must be bit-identical in both builds for every index.

Decomposition:
- Package cos_lut_pkg holds:
  - localparams ADDR_W = $clog2(SAMPLES_PER_PERIOD) and OUT_WIDTH/FRAC_BITS defaults;
  - typedef fixdt24_t (logic signed [23:0]);
  - elaboration function cos_fix(k, N) returning fixdt24_t.
- One sub-module, cos_lut_port: one read port containing quadrant fold (when enabled) plus output register.
- cos_lut instantiates cos_lut_port in a generate loop over READ_PORTS; the table constant is shared.

Test Plan:
- Reset: rst=1 for 2 cycles with in=5 -> out=0x000000; first edge after release -> cos(5) entry.
- Full sweep, READ_PORTS=1, N=64: in = 0..63, one per cycle -> one cycle later:
  - in=0 -> 0x400000
  - in=8 -> 0x2D413D
  - in=16 -> 0x000000
  - in=24 -> 0xD2BEC3
  - in=32 -> 0xC00000
  - in=48 -> 0x000000
  - in=56 -> 0x2D413D
- Wrap: in 63 -> 0 -> 1 on consecutive cycles -> outputs cos(63), 0x400000, cos(1); cos(63) == cos(1).
- Symmetry check over all k: out(k+32) == -out(k) and out(64-k) == out(k), bit-exact.
- Multi-port, READ_PORTS=2: in[0]=0 and in[1]=32 simultaneously -> 0x400000 and 0xC00000 same cycle; then both ports at 8 -> both 0x2D413D.
- Build with and without COS_LUT_QUARTER_WAVE_EN: run the sweep under both builds -> identical output streams.

Source files
------------

// File: rtl/cos_lut_pkg.sv
// cos_lut_pkg: shared constants, the Q2.22 sample type and the
// elaboration-time cosine generator used to fill the cos_lut table.
// Optional build macro handled by users of this package: COS_LUT_QUARTER_WAVE_EN.
package cos_lut_pkg;

   localparam int CARRIER_SAMPLES_PER_PERIOD = 64;
   localparam int ADDR_W                     = $clog2(CARRIER_SAMPLES_PER_PERIOD);
   localparam int FIXDT_24_WIDTH             = 24;
   localparam int FIXDT_24_FRAC              = 22;

   // Internal working precision of the generator (Q?.30); output is
   // rounded down from this, so FRAC_BITS must not exceed it.
   localparam int     CALC_FRAC = 30;
   // pi scaled by 2^40.
   localparam longint PI_Q40    = 64'sd3454217652358;

   typedef logic signed [23:0] fixdt24_t;

   // cos(2*pi*k/n) * 2^frac, rounded half away from zero.
   // The angle is folded into the first quadrant before evaluation and the
   // sign reapplied afterwards, so the symmetry relations of the cosine hold
   // bit for bit and +/-1.0 and 0 are produced exactly.
   function automatic longint cos_fix_raw(input int k, input int n, input int frac);
      longint x;
      longint x2;
      longint term;
      longint sum;
      int     quarter;
      int     kk;
      int     q;
      int     r;
      int     m;
      bit     neg;
      quarter = n / 4;
      kk      = k % n;
      q       = kk / quarter;
      r       = kk % quarter;
      m       = (q == 1 || q == 3) ? quarter - r : r;
      neg     = (q == 1 || q == 2);
      if (m == 0) begin
         sum = 64'sd1 <<< CALC_FRAC;
      end else if (m == quarter) begin
         sum = 64'sd0;
      end else begin
         x    = (PI_Q40 * 2 * m / n) >>> 10;
         x2   = (x * x) >>> CALC_FRAC;
         sum  = 64'sd1 <<< CALC_FRAC;
         term = sum;
         // Taylor series; 12 terms are far below one output LSB at pi/2.
         for (int i = 1; i <= 12; i++) begin
            term = -((term * x2) >>> CALC_FRAC) / ((2 * i - 1) * (2 * i));
            sum  = sum + term;
         end
      end
      // Magnitude is non-negative here, so adding half is round-half-away.
      if (frac < CALC_FRAC) begin
         sum = (sum + (64'sd1 <<< (CALC_FRAC - frac - 1))) >>> (CALC_FRAC - frac);
      end
      return neg ? -sum : sum;
   endfunction

   // Codebase-format convenience wrapper (Q2.22, 24 bits).
   function automatic fixdt24_t cos_fix(input int k, input int n);
      return fixdt24_t'(cos_fix_raw(k, n, FIXDT_24_FRAC));
   endfunction

endpackage

// File: rtl/cos_lut_port.sv
// cos_lut_port: one read port of the cosine table with its output register.
// With COS_LUT_QUARTER_WAVE_EN defined the table holds only k = 0..N/4 and
// the phase index is folded by quadrant in front of the register; otherwise
// the full table is indexed directly. Latency is one cycle in both builds.
module cos_lut_port
   import cos_lut_pkg::*;
#(
   parameter int AW        = ADDR_W,
   parameter int OUT_WIDTH = FIXDT_24_WIDTH,
   parameter int ENTRIES   = CARRIER_SAMPLES_PER_PERIOD,
   parameter logic [ENTRIES*OUT_WIDTH-1:0] TABLE = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [AW-1:0]        idx,
   output logic [OUT_WIDTH-1:0] data
);

   logic [OUT_WIDTH-1:0] data_d;
   logic [OUT_WIDTH-1:0] data_q;

`ifdef COS_LUT_QUARTER_WAVE_EN
   localparam logic [AW-2:0] QUARTER = (AW-1)'(1 << (AW - 2));

   logic [1:0]           quad;
   logic [AW-3:0]        off;
   logic [AW-2:0]        rom_idx;
   logic                 neg;
   logic [OUT_WIDTH-1:0] mag;

   // Quadrant fold: mirror the offset in quadrants 1/3, negate in 1/2.
   always_comb begin
      quad    = idx[AW-1:AW-2];
      off     = idx[AW-3:0];
      rom_idx = quad[0] ? (QUARTER - {1'b0, off}) : {1'b0, off};
      neg     = quad[1] ^ quad[0];
      mag     = TABLE[int'(rom_idx)*OUT_WIDTH +: OUT_WIDTH];
      data_d  = neg ? -mag : mag;
   end
`else
   // Direct lookup into the full-period table.
   always_comb begin
      data_d = TABLE[int'(idx)*OUT_WIDTH +: OUT_WIDTH];
   end
`endif

   // Output register with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) data_q <= '0;
      else     data_q <= data_d;
   end

   assign data = data_q;

endmodule

// File: rtl/cos_lut.sv
// cos_lut: synchronous cosine look-up table, signed Q2.22 output, one-cycle
// latency, READ_PORTS independent read ports sharing one constant table.
// Build macro COS_LUT_QUARTER_WAVE_EN selects quarter-wave storage with
// identical output values.
module cos_lut
   import cos_lut_pkg::*;
#(
   parameter int READ_PORTS         = 1,
   parameter int SAMPLES_PER_PERIOD = CARRIER_SAMPLES_PER_PERIOD,
   parameter int OUT_WIDTH          = FIXDT_24_WIDTH,
   parameter int FRAC_BITS          = FIXDT_24_FRAC
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [$clog2(SAMPLES_PER_PERIOD)-1:0] in  [READ_PORTS],
   output logic [OUT_WIDTH-1:0]                  out [READ_PORTS]
);

   localparam int AW = $clog2(SAMPLES_PER_PERIOD);

`ifdef COS_LUT_QUARTER_WAVE_EN
   localparam int ENTRIES = SAMPLES_PER_PERIOD / 4 + 1;
`else
   localparam int ENTRIES = SAMPLES_PER_PERIOD;
`endif

   // Table image built once at elaboration; entry k sits at bits [k*W +: W].
   function automatic logic [ENTRIES*OUT_WIDTH-1:0] build_table();
      logic [ENTRIES*OUT_WIDTH-1:0] tbl;
      tbl = '0;
      for (int k = 0; k < ENTRIES; k++) begin
         tbl[k*OUT_WIDTH +: OUT_WIDTH] =
            OUT_WIDTH'(cos_fix_raw(k, SAMPLES_PER_PERIOD, FRAC_BITS));
      end
      return tbl;
   endfunction

   localparam logic [ENTRIES*OUT_WIDTH-1:0] TABLE = build_table();

   for (genvar g = 0; g < READ_PORTS; g++) begin : g_port
      cos_lut_port #(
         .AW        (AW),
         .OUT_WIDTH (OUT_WIDTH),
         .ENTRIES   (ENTRIES),
         .TABLE     (TABLE)
      ) u_port (
         .clk  (clk),
         .rst  (rst),
         .idx  (in[g]),
         .data (out[g])
      );
   end

endmodule

// File: tb/tb_cos_lut.sv
// tb_cos_lut: scoreboard bench for cos_lut (two read ports, N = 64).
// Expected samples come from a real-valued cosine reference rounded half
// away from zero; valid for builds with and without COS_LUT_QUARTER_WAVE_EN.
module tb_cos_lut;
   import cos_lut_pkg::*;

   localparam int    N     = 64;
   localparam int    PORTS = 2;
   localparam real   PI    = 3.14159265358979323846;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] in_s  [PORTS];
   logic [23:0]       out_s [PORTS];

   logic [23:0] exp_q0 [$];
   logic [23:0] exp_q1 [$];
   int          tag_q  [$];
   logic [23:0] sweep_out [N];

   int n_checks;
   int n_fail;

   cos_lut #(
      .READ_PORTS         (PORTS),
      .SAMPLES_PER_PERIOD (N),
      .OUT_WIDTH          (24),
      .FRAC_BITS          (22)
   ) dut (
      .clk (clk),
      .rst (rst),
      .in  (in_s),
      .out (out_s)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: round_half_away(cos(2*pi*k/N) * 2^22)
   function automatic logic [23:0] ref_cos(input int k);
      real v;
      real r;
      v = $cos(2.0 * PI * real'(k) / real'(N)) * 4194304.0;
      if (v >= 0.0) r = $floor(v + 0.5);
      else          r = -$floor(-v + 0.5);
      return 24'($rtoi(r));
   endfunction

   // Known test-plan values, otherwise the reference model
   function automatic logic [23:0] exp_for(input int k);
      case (k)
         0:       return 24'h400000;
         8:       return 24'h2D413D;
         16:      return 24'h000000;
         24:      return 24'hD2BEC3;
         32:      return 24'hC00000;
         48:      return 24'h000000;
         56:      return 24'h2D413D;
         default: return ref_cos(k);
      endcase
   endfunction

   task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %06h expected %06h", name, got, exp);
      end
   endtask

   // Driver: one read per cycle; the expected response is queued at issue
   task automatic drive(input logic r, input int a0, input int a1, input int tag);
      @(negedge clk);
      rst     = r;
      in_s[0] = ADDR_W'(a0);
      in_s[1] = ADDR_W'(a1);
      exp_q0.push_back(r ? 24'h0 : exp_for(a0));
      exp_q1.push_back(r ? 24'h0 : exp_for(a1));
      tag_q.push_back(r ? -1 : tag);
   endtask

   // Monitor: each edge after an issued read presents one sample per port
   initial begin
      logic [23:0] e0;
      logic [23:0] e1;
      int          t;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q0.size() != 0) begin
            e0 = exp_q0.pop_front();
            e1 = exp_q1.pop_front();
            t  = tag_q.pop_front();
            check("port0", out_s[0], e0);
            check("port1", out_s[1], e1);
            if (t >= 0) sweep_out[t] = out_s[0];
         end
      end
   end

   // Stimulus
   initial begin
      int w;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      in_s[0]  = ADDR_W'(5);
      in_s[1]  = ADDR_W'(5);

      // Reset holds outputs at zero; first edge after release gives cos(5)
      drive(1'b1, 5, 5, -1);
      drive(1'b1, 5, 5, -1);
      drive(1'b0, 5, 5, -1);

      // Full sweep on port 0, random addresses on port 1
      for (int k = 0; k < N; k++) drive(1'b0, k, $urandom_range(0, N - 1), k);

      // Index wrap 63 -> 0 -> 1
      drive(1'b0, 63, 63, -1);
      drive(1'b0, 0, 0, -1);
      drive(1'b0, 1, 1, -1);

      // Two ports, different then identical addresses
      drive(1'b0, 0, 32, -1);
      drive(1'b0, 8, 8, -1);

      // Random traffic with occasional mid-stream reset
      repeat (300) begin
         drive($urandom_range(0, 19) == 0, $urandom_range(0, N - 1),
               $urandom_range(0, N - 1), -1);
      end
      @(negedge clk);
      rst = 1'b0;

      // Drain with a bounded wait
      w = 0;
      while (exp_q0.size() != 0 && w < 20) begin
         @(posedge clk);
         #2;
         w++;
      end
      n_checks++;
      if (exp_q0.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d samples outstanding, expected 0", exp_q0.size());
      end

      // Symmetry of the captured sweep, bit exact
      for (int k = 0; k < N / 2; k++) begin
         check($sformatf("sym_half k=%0d", k), sweep_out[k + N / 2], 24'(-sweep_out[k]));
      end
      for (int k = 1; k < N; k++) begin
         check($sformatf("sym_mirror k=%0d", k), sweep_out[N - k], sweep_out[k]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
